sim_run_ctrl: RTL
=================

SIM_RUN_CTRL -- requirements
Module: sim_run_ctrl

Interface
REQ-001 Parameter XLEN, default 64, register/PC width in bits.
REQ-002 Parameter NUM_REGS, default 32, number of architectural registers dumped.
REQ-003 Parameter RESET_CYCLES, default 1, cycles core_reset is held after reset deassert (>=1).
REQ-004 Parameter MAX_CYCLES, default 60, RUN-cycle budget before timeout halt (>=1).
REQ-005 Parameter CNT_W, default 32, cycle_count width.
REQ-006 clock  in  1  single clock; all state on rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 except  in  1  core exception flag, sampled in RUN only.
REQ-009 pc  in  XLEN  core program counter.
REQ-010 debug_reg_in  in  NUM_REGS*XLEN  flattened register file; register i at bits [i*XLEN +: XLEN].
REQ-011 core_reset  out  1  reset to core.
REQ-012 core_run  out  1  core clock-enable; low freezes core state.
REQ-013 dump_valid  out  1  dump beat valid.
REQ-014 dump_ready  in  1  sink accepts beat.
REQ-015 dump_data  out  XLEN  beat payload.
REQ-016 dump_index  out  clog2(NUM_REGS+1)  beat index.
REQ-017 dump_last  out  1  final beat marker.
REQ-018 halt_cause  out  2  bit0 timeout, bit1 exception.
REQ-019 cycle_count  out  CNT_W  RUN cycles elapsed.
REQ-020 done  out  1  dump complete, sticky.

Function
REQ-021 FSM states HOLD, RUN, DUMP, DONE; no other states reachable.
REQ-022 HOLD: core_reset=1, core_run=0; after RESET_CYCLES cycles in HOLD -> RUN.
REQ-023 RUN: core_reset=0, core_run=1; cycle_count increments by 1 each RUN cycle, saturating at all-ones.
REQ-024 RUN: except=1 sets halt_cause[1]; cycle_count reaching MAX_CYCLES sets halt_cause[0]; either -> DUMP next cycle.
REQ-025 Simultaneous except and timeout in same cycle sets both halt_cause bits.
REQ-026 except outside RUN ignored; halt_cause held after halt until reset.
REQ-027 DUMP/DONE: core_run=0, core_reset=0, cycle_count frozen.
REQ-028 DUMP: dump_valid=1; beat k carries register k, k=0..NUM_REGS-1, dump_index=k.
REQ-029 Beat transfers when dump_valid&dump_ready; index advances next cycle; dump_data/dump_index/dump_last stable while dump_ready=0.
REQ-030 dump_last=1 on final beat only; transfer of final beat -> DONE.
REQ-031 DONE: dump_valid=0, done=1, held until reset.
REQ-032 dump_data is combinational mux of debug_reg_in (and pc) by dump_index; core is frozen so data is stable.

Reset
REQ-033 reset=1 at any time (including mid-DUMP) -> HOLD immediately; beat in flight abandoned.
REQ-034 Reset values: core_reset=1, core_run=0, dump_valid=0, dump_data=0, dump_index=0, dump_last=0, halt_cause=0, cycle_count=0, done=0.
REQ-035 HOLD counter starts at reset deassertion.

Configuration
REQ-036 Macro SIM_RUN_CTRL_DUMP_PC_EN defined: one extra beat after register NUM_REGS-1 with dump_index=NUM_REGS, dump_data=pc, dump_last on this beat; total NUM_REGS+1 beats.
REQ-037 Macro undefined: NUM_REGS beats only; dump_last on register NUM_REGS-1; pc port present but unused.

Verification
REQ-038 Defaults, except never set, dump_ready=1 -> core_reset falls 1 cycle after reset release; halt at cycle_count=60, halt_cause=2'b01; 32 beats index 0..31 on consecutive cycles; done after beat 31.
REQ-039 except pulsed on 10th RUN cycle -> halt_cause=2'b10, cycle_count=10, core_run low from next cycle.
REQ-040 except asserted on cycle 60 -> halt_cause=2'b11.
REQ-041 dump_ready toggled 1,0,0,1 with reg3=0xDEADBEEF -> index 3 beat held for 2 stall cycles with data 0xDEADBEEF, no beat skipped or duplicated.
REQ-042 reset asserted during beat 5 -> all outputs at reset values same cycle; full run-and-dump repeats correctly after release.
REQ-043 SIM_RUN_CTRL_DUMP_PC_EN defined, pc=0x400020 -> 33 beats, beat 32 index 32 data 0x400020 dump_last=1; undefined -> 32 beats, dump_last on beat 31.

Source files
------------

// File: rtl/sim_run_ctrl_if.sv
// Register-dump stream carried from sim_run_ctrl to its sink.
// A beat transfers on a rising edge where dump_valid and dump_ready are both high; the sender holds
// dump_data/dump_index/dump_last steady while dump_valid is high and dump_ready is low.
interface sim_run_ctrl_if #(
    parameter int XLEN     = 64,
    parameter int NUM_REGS = 32
);
    localparam int IDX_W = $clog2(NUM_REGS + 1);

    logic             dump_valid;
    logic             dump_ready;
    logic [XLEN-1:0]  dump_data;
    logic [IDX_W-1:0] dump_index;
    logic             dump_last;

    modport master (output dump_valid, dump_data, dump_index, dump_last, input dump_ready);
    modport slave  (input dump_valid, dump_data, dump_index, dump_last, output dump_ready);
endinterface

// File: rtl/sim_run_ctrl.sv
// Simulation run controller: holds the core in reset, runs it until an exception or a cycle budget,
// then streams the frozen register file out. SIM_RUN_CTRL_DUMP_PC_EN appends the pc as a final beat.
module sim_run_ctrl #(
    parameter int XLEN         = 64,
    parameter int NUM_REGS     = 32,
    parameter int RESET_CYCLES = 1,
    parameter int MAX_CYCLES   = 60,
    parameter int CNT_W        = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     except,
    input  logic [XLEN-1:0]          pc,
    input  logic [NUM_REGS*XLEN-1:0] debug_reg_in,
    output logic                     core_reset,
    output logic                     core_run,
    sim_run_ctrl_if.master           dump,
    output logic [1:0]               halt_cause,
    output logic [CNT_W-1:0]         cycle_count,
    output logic                     done,
    output logic [1:0]               dbg_state
);
    localparam int IDX_W = $clog2(NUM_REGS + 1);
`ifdef SIM_RUN_CTRL_DUMP_PC_EN
    localparam int LAST_IDX = NUM_REGS;
`else
    localparam int LAST_IDX = NUM_REGS - 1;
`endif
    localparam int HC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_HOLD = 2'd0,
        S_RUN  = 2'd1,
        S_DUMP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state, state_next;
    logic [HC_W-1:0]  hold_cnt;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt_inc;
    logic             hold_end;
    logic             timeout;
    logic             is_last;
    logic             beat_fire;

    assign dbg_state = state;

    // The budget test uses the post-increment count so RUN lasts exactly MAX_CYCLES cycles.
    always_comb begin
        cnt_inc   = (&cycle_count) ? cycle_count : cycle_count + CNT_W'(1);
        timeout   = ({1'b0, cnt_inc} >= (CNT_W + 1)'(MAX_CYCLES));
        hold_end  = (hold_cnt == HC_W'(RESET_CYCLES - 1));
        is_last   = (idx == IDX_W'(LAST_IDX));
        beat_fire = (state == S_DUMP) && dump.dump_ready;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_HOLD:  if (hold_end) state_next = S_RUN;
            S_RUN:   if (except || timeout) state_next = S_DUMP;
            S_DUMP:  if (beat_fire && is_last) state_next = S_DONE;
            S_DONE:  state_next = S_DONE;
            default: state_next = S_HOLD;
        endcase
    end

    always_comb begin
        core_reset      = (state == S_HOLD);
        core_run        = (state == S_RUN);
        dump.dump_valid = (state == S_DUMP);
        dump.dump_last  = (state == S_DUMP) && is_last;
        dump.dump_index = idx;
        done            = (state == S_DONE);
    end

    // Payload is zero outside DUMP so a mid-dump reset clears it in the same cycle.
    always_comb begin
        dump.dump_data = '0;
        if (state == S_DUMP) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (idx == IDX_W'(i)) dump.dump_data = debug_reg_in[i*XLEN +: XLEN];
            end
`ifdef SIM_RUN_CTRL_DUMP_PC_EN
            if (idx == IDX_W'(NUM_REGS)) dump.dump_data = pc;
`endif
        end
    end

`ifndef SIM_RUN_CTRL_DUMP_PC_EN
    logic unused_pc;
    assign unused_pc = ^pc;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_HOLD;
            hold_cnt    <= '0;
            idx         <= '0;
            cycle_count <= '0;
            halt_cause  <= 2'b00;
        end else begin
            state <= state_next;
            if (state == S_HOLD && !hold_end) hold_cnt <= hold_cnt + HC_W'(1);
            if (state == S_RUN) begin
                cycle_count <= cnt_inc;
                if (except)  halt_cause[1] <= 1'b1;
                if (timeout) halt_cause[0] <= 1'b1;
            end
            if (beat_fire && !is_last) idx <= idx + IDX_W'(1);
        end
    end
endmodule
